sdp_fifo_ctrl: RTL and testbench

- Circular-buffer FIFO controller sitting directly upstream of the simple dual-port RAM block (sdp).
- Converts an incoming dti data stream into write address/data transactions.
- Issues read addresses in FIFO order and tracks occupancy.
- Read data returns through the RAM's read port. Controller plus RAM form a dti FIFO.

---
 rtl/sdp_fifo_ctrl.sv | 71 +++++++
 tb/tb_sdp_fifo_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_fifo_ctrl.sv
// Circular-buffer FIFO controller feeding a simple dual-port RAM.
// Turns an incoming stream into RAM writes and issues read addresses in FIFO order.
module sdp_fifo_ctrl #(
    parameter int W_DATA = 16,
    parameter int W_ADDR = 10,
    parameter int DEPTH  = 1024,
    localparam int W_CNT = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // a producer holds valid and data stable until that transfer.
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic [W_DATA-1:0]          din_data,
    output logic                       wr_addr_data_valid,
    input  logic                       wr_addr_data_ready,
    output logic [W_DATA+W_ADDR-1:0]   wr_addr_data_data,
    output logic                       rd_addr_valid,
    input  logic                       rd_addr_ready,
    output logic [W_ADDR-1:0]          rd_addr_data,
    output logic [W_CNT-1:0]           count,
    output logic                       empty,
    output logic                       full
);

    localparam logic [W_ADDR-1:0] LAST_PTR = W_ADDR'(DEPTH - 1);
    localparam logic [W_CNT-1:0]  FULL_CNT = W_CNT'(DEPTH);

    logic [W_ADDR-1:0] wr_ptr;
    logic [W_ADDR-1:0] rd_ptr;
    logic [W_CNT-1:0]  count_q;
    logic              wr_fire;
    logic              rd_fire;

    // Wrap at DEPTH-1 so non-power-of-two depths never touch unused RAM rows.
    function automatic logic [W_ADDR-1:0] next_ptr(input logic [W_ADDR-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Flags come only from the registered count, so rd_addr_ready never reaches din_ready.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    assign din_ready          = !rst && !full && wr_addr_data_ready;
    assign wr_addr_data_valid = !rst && din_valid && !full;
    assign wr_addr_data_data  = {din_data, wr_ptr};
    assign rd_addr_valid      = !rst && !empty;
    assign rd_addr_data       = rd_ptr;

    assign wr_fire = din_valid && din_ready;
    assign rd_fire = rd_addr_valid && rd_addr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_fire) wr_ptr <= next_ptr(wr_ptr);
            if (rd_fire) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Bench for sdp_fifo_ctrl: a DEPTH=4 and a DEPTH=3 instance, each with a behavioural RAM
// and a scoreboard queue checked whenever read data returns.
module tb_sdp_fifo_ctrl;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    // DEPTH=4 instance
    logic       a_din_valid, a_din_ready;
    logic [7:0] a_din_data;
    logic       a_wr_valid, a_wr_ready;
    logic [9:0] a_wr_data;
    logic       a_rd_valid, a_rd_ready;
    logic [1:0] a_rd_addr;
    logic [2:0] a_count;
    logic       a_empty, a_full;
    logic [7:0] a_mem [4];
    logic [7:0] a_rd_data;
    logic       a_rd_data_valid;
    logic [7:0] a_exp_q [$];

    // DEPTH=3 instance
    logic       b_din_valid, b_din_ready;
    logic [7:0] b_din_data;
    logic       b_wr_valid, b_wr_ready;
    logic [9:0] b_wr_data;
    logic       b_rd_valid, b_rd_ready;
    logic [1:0] b_rd_addr;
    logic [1:0] b_count;
    logic       b_empty, b_full;
    logic [7:0] b_mem [4];
    logic [7:0] b_rd_data;
    logic       b_rd_data_valid;
    logic [7:0] b_exp_q [$];

    sdp_fifo_ctrl #(.W_DATA(8), .W_ADDR(2), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst),
        .din_valid(a_din_valid), .din_ready(a_din_ready), .din_data(a_din_data),
        .wr_addr_data_valid(a_wr_valid), .wr_addr_data_ready(a_wr_ready),
        .wr_addr_data_data(a_wr_data),
        .rd_addr_valid(a_rd_valid), .rd_addr_ready(a_rd_ready), .rd_addr_data(a_rd_addr),
        .count(a_count), .empty(a_empty), .full(a_full)
    );

    sdp_fifo_ctrl #(.W_DATA(8), .W_ADDR(2), .DEPTH(3)) dut_b (
        .clk(clk), .rst(rst),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .din_data(b_din_data),
        .wr_addr_data_valid(b_wr_valid), .wr_addr_data_ready(b_wr_ready),
        .wr_addr_data_data(b_wr_data),
        .rd_addr_valid(b_rd_valid), .rd_addr_ready(b_rd_ready), .rd_addr_data(b_rd_addr),
        .count(b_count), .empty(b_empty), .full(b_full)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // RAM models plus expected-queue push on every accepted input word
    always @(posedge clk) begin
        a_rd_data_valid <= 1'b0;
        if (a_wr_valid && a_wr_ready) a_mem[a_wr_data[1:0]] <= a_wr_data[9:2];
        if (a_rd_valid && a_rd_ready) begin
            a_rd_data       <= a_mem[a_rd_addr];
            a_rd_data_valid <= 1'b1;
        end
        if (rst) a_exp_q.delete();
        else if (a_din_valid && a_din_ready) a_exp_q.push_back(a_din_data);
    end

    always @(posedge clk) begin
        b_rd_data_valid <= 1'b0;
        if (b_wr_valid && b_wr_ready) b_mem[b_wr_data[1:0]] <= b_wr_data[9:2];
        if (b_rd_valid && b_rd_ready) begin
            b_rd_data       <= b_mem[b_rd_addr];
            b_rd_data_valid <= 1'b1;
        end
        if (rst) b_exp_q.delete();
        else if (b_din_valid && b_din_ready) b_exp_q.push_back(b_din_data);
    end

    // Monitors: pop and compare whenever read data returns; occupancy bound every cycle
    always @(negedge clk) begin
        if (a_rd_data_valid) begin
            if (a_exp_q.size() == 0) check("a_rd_data_unexpected", 32'(a_rd_data), 32'hxxxx_xxxx);
            else check("a_rd_data", 32'(a_rd_data), 32'(a_exp_q.pop_front()));
        end
        if (b_rd_data_valid) begin
            if (b_exp_q.size() == 0) check("b_rd_data_unexpected", 32'(b_rd_data), 32'hxxxx_xxxx);
            else check("b_rd_data", 32'(b_rd_data), 32'(b_exp_q.pop_front()));
        end
        check("a_count_bound", 32'(a_count <= 3'd4), 32'd1);
        check("b_count_bound", 32'(b_count <= 2'd3), 32'd1);
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [7:0] d);
        a_din_valid = 1'b1;
        a_din_data  = d;
        tick();
        a_din_valid = 1'b0;
    endtask

    logic [7:0] fill_d   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [9:0] fill_w   [4] = '{10'h044, 10'h089, 10'h0CE, 10'h113};
    logic [1:0] drain_a  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst = 1'b1;
        a_din_valid = 1'b0; a_din_data = '0; a_wr_ready = 1'b1; a_rd_ready = 1'b0;
        b_din_valid = 1'b0; b_din_data = '0; b_wr_ready = 1'b1; b_rd_ready = 1'b0;

        // Reset
        tick();
        #1;
        check("rst_din_ready", 32'(a_din_ready), 32'd0);
        check("rst_rd_valid", 32'(a_rd_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("reset_count", 32'(a_count), 32'd0);
        check("reset_empty", 32'(a_empty), 32'd1);
        check("reset_full", 32'(a_full), 32'd0);
        check("reset_rd_valid", 32'(a_rd_valid), 32'd0);
        check("reset_din_ready", 32'(a_din_ready), 32'd1);
        check("reset_wr_valid", 32'(a_wr_valid), 32'd0);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            a_din_valid = 1'b1;
            a_din_data  = fill_d[i];
            #1;
            check("fill_wr_valid", 32'(a_wr_valid), 32'd1);
            check("fill_wr_data", 32'(a_wr_data), 32'(fill_w[i]));
            check("fill_count", 32'(a_count), 32'(i));
            check("fill_din_ready", 32'(a_din_ready), 32'd1);
            tick();
        end
        a_din_data = 8'h55;
        #1;
        check("full_count", 32'(a_count), 32'd4);
        check("full_flag", 32'(a_full), 32'd1);
        check("full_din_ready", 32'(a_din_ready), 32'd0);
        check("full_wr_valid", 32'(a_wr_valid), 32'd0);

        // Full + read: write blocked this cycle, accepted the next
        a_rd_ready = 1'b1;
        #1;
        check("fullrd_rd_valid", 32'(a_rd_valid), 32'd1);
        check("fullrd_rd_addr", 32'(a_rd_addr), 32'd0);
        check("fullrd_din_ready", 32'(a_din_ready), 32'd0);
        tick();
        a_rd_ready = 1'b0;
        #1;
        check("fullrd2_count", 32'(a_count), 32'd3);
        check("fullrd2_din_ready", 32'(a_din_ready), 32'd1);
        check("fullrd2_wr_data", 32'(a_wr_data), 32'h154);
        check("fullrd2_rd_addr", 32'(a_rd_addr), 32'd1);
        tick();
        a_din_valid = 1'b0;
        #1;
        check("fullrd3_count", 32'(a_count), 32'd4);
        check("fullrd3_full", 32'(a_full), 32'd1);

        // Drain
        a_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_rd_valid", 32'(a_rd_valid), 32'd1);
            check("drain_rd_addr", 32'(a_rd_addr), 32'(drain_a[i]));
            tick();
        end
        #1;
        check("drained_count", 32'(a_count), 32'd0);
        check("drained_empty", 32'(a_empty), 32'd1);
        check("drained_rd_valid", 32'(a_rd_valid), 32'd0);

        // Empty: write visible to the read side one cycle later
        a_din_valid = 1'b1;
        a_din_data  = 8'h66;
        #1;
        check("vis_n_rd_valid", 32'(a_rd_valid), 32'd0);
        check("vis_n_wr_data", 32'(a_wr_data), 32'h199);
        tick();
        a_din_valid = 1'b0;
        #1;
        check("vis_n1_rd_valid", 32'(a_rd_valid), 32'd1);
        check("vis_n1_rd_addr", 32'(a_rd_addr), 32'd1);
        check("vis_n1_count", 32'(a_count), 32'd1);
        tick();
        #1;
        check("vis_rd_data_valid", 32'(a_rd_data_valid), 32'd1);
        check("vis_rd_data", 32'(a_rd_data), 32'h66);
        check("vis_count", 32'(a_count), 32'd0);

        // Backpressure then mid-operation reset
        a_rd_ready = 1'b0;
        a_write(8'hA1);
        a_write(8'hA2);
        a_write(8'hA3);
        a_wr_ready  = 1'b0;
        a_din_valid = 1'b1;
        a_din_data  = 8'hA4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_din_ready", 32'(a_din_ready), 32'd0);
            check("bp_wr_valid", 32'(a_wr_valid), 32'd1);
            check("bp_count", 32'(a_count), 32'd3);
            tick();
        end
        a_wr_ready = 1'b1;
        a_din_data = 8'hEE;
        rst = 1'b1;
        #1;
        check("midrst_din_ready", 32'(a_din_ready), 32'd0);
        check("midrst_wr_valid", 32'(a_wr_valid), 32'd0);
        check("midrst_rd_valid", 32'(a_rd_valid), 32'd0);
        tick();
        rst = 1'b0;
        a_din_valid = 1'b0;
        #1;
        check("postrst_count", 32'(a_count), 32'd0);
        check("postrst_empty", 32'(a_empty), 32'd1);
        check("postrst_rd_valid", 32'(a_rd_valid), 32'd0);
        a_din_valid = 1'b1;
        a_din_data  = 8'hB7;
        #1;
        check("postrst_wr_data", 32'(a_wr_data), 32'h2DC);
        tick();
        a_din_valid = 1'b0;
        a_rd_ready  = 1'b1;
        #1;
        check("postrst_rd_addr", 32'(a_rd_addr), 32'd0);
        check("postrst_rd_valid2", 32'(a_rd_valid), 32'd1);
        tick();
        a_rd_ready = 1'b0;
        tick();

        // DEPTH=3 sustained wrap
        b_din_valid = 1'b1;
        b_din_data  = 8'h01;
        tick();
        b_din_data  = 8'h02;
        tick();
        b_rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b_din_data = 8'h10 + 8'(i);
            #1;
            check("wrap_count", 32'(b_count), 32'd2);
            check("wrap_din_ready", 32'(b_din_ready), 32'd1);
            check("wrap_wr_addr", 32'(b_wr_data[1:0]), 32'((2 + i) % 3));
            check("wrap_rd_addr", 32'(b_rd_addr), 32'(i % 3));
            tick();
        end
        b_din_valid = 1'b0;
        tick();
        tick();
        b_rd_ready = 1'b0;
        #1;
        check("wrap_drained_count", 32'(b_count), 32'd0);
        tick();
        tick();

        check("a_queue_empty", 32'(a_exp_q.size()), 32'd0);
        check("b_queue_empty", 32'(b_exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
